ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. Consumes the ID/EX buffer outputs and feeds the MEM stage.
- Performs the ALU operation and holds the architectural Z/N flag register.
- Resolves J/BRZ/BRN redirects and squashes the wrong-path instructions that follow a taken redirect.
- jumpMem is not resolved here; it is passed through to MEM.

Parameters:
- WIDTH, 32, datapath width.
- SQUASH_SLOTS, 2, number of younger instructions killed after a taken redirect; legal range 1..3.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all EX/MEM state (MEM busy)
- aluOp_ex  in  3  ALU operation
- aluSrc_ex  in  1  1: operand B = y_ex; 0: operand B = xrt_ex
- memRead_ex, memWrite_ex, regWrt_ex, branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex  in  1 each  control from ID/EX
- writeBackControl_ex  in  2  writeback select
- pc_plus_y_ex, xrs_ex, xrt_ex, y_ex  in  WIDTH each  operands from ID/EX
- redirect  out  1  combinational; PC must load target this cycle
- redirect_target  out  WIDTH  combinational; equals xrs_ex
- alu_result_mem, xrt_mem, pc_plus_y_mem  out  WIDTH each  registered
- memRead_mem, memWrite_mem, regWrt_mem, jumpMem_mem, valid_mem  out  1 each  registered
- writeBackControl_mem  out  2  registered
- flag_z, flag_n  out  1 each  current flag register

Behaviour:
- Reset (async): all registered outputs 0; flag_z=0, flag_n=0; squash counter sq_cnt=0.
- Operand A = xrs_ex. Operand B = aluSrc_ex ? y_ex : xrt_ex.
- ALU, combinational, WIDTH-bit, wrap-around, no overflow detection:
  - 000 A+B; 001 A-B; 010 0-A; 011 A; 100 B; 101 A&B; 110 A|B; 111 result 0.
- live = (sq_cnt==0) && !stall.
- Branch decision uses flag values from before the current instruction:
  - taken = live && (jump_ex || (branchZero_ex && flag_z) || (branchNeg_ex && flag_n)).
  - redirect = taken; redirect_target = xrs_ex always.
- Flag update, at a clock edge where live && regWrt_ex && !memRead_ex:
  - flag_z <= (alu==0); flag_n <= alu[WIDTH-1].
  - Otherwise flags hold. Loads and squashed instructions never touch flags.
- Squash counter, evaluated in priority order at each edge:
  - stall=1: sq_cnt holds.
  - else if taken: sq_cnt <= SQUASH_SLOTS.
  - else if sq_cnt>0: sq_cnt <= sq_cnt-1.
- Squashed instruction (sq_cnt>0, not stalled):
  - Treated as a bubble; cannot redirect, update flags, or set control outputs.
  - A branch arriving in a squash slot is ignored.
- EX/MEM register, one-cycle latency:
  - stall=1: every _mem output holds, flags hold, redirect=0.
  - else if sq_cnt>0: valid_mem=0 and memRead_mem, memWrite_mem, regWrt_mem, jumpMem_mem = 0. Data outputs load normally (don't-care).
  - else: valid_mem=1; alu_result_mem=alu; xrt_mem=xrt_ex; pc_plus_y_mem=pc_plus_y_ex; all control fields copied.
- The taken branch itself passes to MEM with valid_mem=1, its own control fields, and regWrt as given.
- Reset asserted mid-squash: sq_cnt cleared immediately. The first instruction after reset release is live.
- Stall during a squash window: the window is extended, not shortened.

Optional Feature:
- Macro EX_PERF_CNT_EN.
- Defined:
  - Adds outputs branch_taken_cnt (32) and squash_cnt (32), both reset to 0 and wrapping at 2^32.
  - branch_taken_cnt increments at each edge where taken=1.
  - squash_cnt increments at each non-stalled edge where sq_cnt>0.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- ALU and flags:
  - Stimulus: aluOp=001, xrs=5, aluSrc=1, y=5, regWrt=1.
  - Response: next cycle alu_result_mem=0, flag_z=1, flag_n=0, valid_mem=1.
  - Then aluOp=000, xrs=0xFFFFFFFF, xrt=1: alu_result_mem=0, flag_z=1.
- BRN taken:
  - Stimulus: prior ALU op 0-3 gives flag_n=1, then branchNeg=1, xrs=0x40.
  - Response: redirect=1 and redirect_target=0x40 that cycle. Next two instructions, including a store, produce valid_mem=0 and memWrite_mem=0. Third instruction valid_mem=1.
- BRZ not taken:
  - Stimulus: flag_z=0, branchZero=1.
  - Response: redirect=0, sq_cnt stays 0, next instruction live.
- Branch in shadow:
  - Stimulus: jump=1, immediately followed by another jump with xrs=0x99.
  - Response: second redirect never asserts; exactly one redirect pulse.
- Stall:
  - Stimulus: stall held 3 cycles during sq_cnt=1.
  - Response: _mem outputs and flags frozen, redirect=0. The squash still consumes one non-stalled slot after release.
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle with sq_cnt=2 and flag_z=1.
  - Response: all outputs 0 immediately, without waiting for a clock edge. The first post-reset instruction has valid_mem=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register, Z/N flag register and redirect squashing.
// Optional EX_PERF_CNT_EN macro adds branch_taken_cnt / squash_cnt counters.
module ex_mem_stage #(
  parameter int WIDTH        = 32,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       aluOp_ex,
  input  logic             aluSrc_ex,
  input  logic             memRead_ex,
  input  logic             memWrite_ex,
  input  logic             regWrt_ex,
  input  logic             branchZero_ex,
  input  logic             branchNeg_ex,
  input  logic             jump_ex,
  input  logic             jumpMem_ex,
  input  logic [1:0]       writeBackControl_ex,
  input  logic [WIDTH-1:0] pc_plus_y_ex,
  input  logic [WIDTH-1:0] xrs_ex,
  input  logic [WIDTH-1:0] xrt_ex,
  input  logic [WIDTH-1:0] y_ex,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] alu_result_mem,
  output logic [WIDTH-1:0] xrt_mem,
  output logic [WIDTH-1:0] pc_plus_y_mem,
  output logic             memRead_mem,
  output logic             memWrite_mem,
  output logic             regWrt_mem,
  output logic             jumpMem_mem,
  output logic             valid_mem,
  output logic [1:0]       writeBackControl_mem,
`ifdef EX_PERF_CNT_EN
  output logic [31:0]      branch_taken_cnt,
  output logic [31:0]      squash_cnt,
`endif
  output logic             flag_z,
  output logic             flag_n
);

  localparam logic [1:0] SQ_INIT = 2'(SQUASH_SLOTS);

  function automatic logic signed [WIDTH-1:0] alu_f(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    case (op)
      3'b000:  alu_f = a + b;
      3'b001:  alu_f = a - b;
      3'b010:  alu_f = -a;
      3'b011:  alu_f = a;
      3'b100:  alu_f = b;
      3'b101:  alu_f = a & b;
      3'b110:  alu_f = a | b;
      default: alu_f = '0;
    endcase
  endfunction

  logic [1:0]              sq_cnt;
  logic                    live;
  logic                    taken;
  logic signed [WIDTH-1:0] opb;
  logic signed [WIDTH-1:0] alu;

  assign opb   = aluSrc_ex ? y_ex : xrt_ex;
  assign alu   = alu_f(aluOp_ex, xrs_ex, opb);
  assign live  = (sq_cnt == 2'd0) && !stall;
  // Flags read here are the ones left by the previous instruction.
  assign taken = live && (jump_ex || (branchZero_ex && flag_z) || (branchNeg_ex && flag_n));

  assign redirect        = taken;
  assign redirect_target = xrs_ex;

  // EX -> MEM boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sq_cnt               <= 2'd0;
      flag_z               <= 1'b0;
      flag_n               <= 1'b0;
      alu_result_mem       <= '0;
      xrt_mem              <= '0;
      pc_plus_y_mem        <= '0;
      memRead_mem          <= 1'b0;
      memWrite_mem         <= 1'b0;
      regWrt_mem           <= 1'b0;
      jumpMem_mem          <= 1'b0;
      valid_mem            <= 1'b0;
      writeBackControl_mem <= 2'd0;
    end else if (!stall) begin
      if (taken)               sq_cnt <= SQ_INIT;
      else if (sq_cnt != 2'd0) sq_cnt <= sq_cnt - 2'd1;

      if (live && regWrt_ex && !memRead_ex) begin
        flag_z <= (alu == '0);
        flag_n <= alu[WIDTH-1];
      end

      alu_result_mem       <= alu;
      xrt_mem              <= xrt_ex;
      pc_plus_y_mem        <= pc_plus_y_ex;
      valid_mem            <= live;
      memRead_mem          <= live & memRead_ex;
      memWrite_mem         <= live & memWrite_ex;
      regWrt_mem           <= live & regWrt_ex;
      jumpMem_mem          <= live & jumpMem_ex;
      writeBackControl_mem <= live ? writeBackControl_ex : 2'd0;
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_taken_cnt <= 32'd0;
      squash_cnt       <= 32'd0;
    end else begin
      if (taken)                        branch_taken_cnt <= branch_taken_cnt + 32'd1;
      if (!stall && (sq_cnt != 2'd0))   squash_cnt       <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector bench for ex_mem_stage: ALU/flags, branches, squash shadow, stall and async reset.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset, stall;
  logic [2:0]  aluOp_ex;
  logic        aluSrc_ex, memRead_ex, memWrite_ex, regWrt_ex;
  logic        branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex;
  logic [1:0]  writeBackControl_ex;
  logic [31:0] pc_plus_y_ex, xrs_ex, xrt_ex, y_ex;
  logic        redirect;
  logic [31:0] redirect_target, alu_result_mem, xrt_mem, pc_plus_y_mem;
  logic        memRead_mem, memWrite_mem, regWrt_mem, jumpMem_mem, valid_mem;
  logic [1:0]  writeBackControl_mem;
  logic        flag_z, flag_n;
`ifdef EX_PERF_CNT_EN
  logic [31:0] branch_taken_cnt, squash_cnt;
`endif

  always #5 clock = ~clock;

  ex_mem_stage #(.WIDTH(32), .SQUASH_SLOTS(2)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .aluOp_ex(aluOp_ex), .aluSrc_ex(aluSrc_ex), .memRead_ex(memRead_ex),
    .memWrite_ex(memWrite_ex), .regWrt_ex(regWrt_ex), .branchZero_ex(branchZero_ex),
    .branchNeg_ex(branchNeg_ex), .jump_ex(jump_ex), .jumpMem_ex(jumpMem_ex),
    .writeBackControl_ex(writeBackControl_ex), .pc_plus_y_ex(pc_plus_y_ex),
    .xrs_ex(xrs_ex), .xrt_ex(xrt_ex), .y_ex(y_ex),
    .redirect(redirect), .redirect_target(redirect_target),
    .alu_result_mem(alu_result_mem), .xrt_mem(xrt_mem), .pc_plus_y_mem(pc_plus_y_mem),
    .memRead_mem(memRead_mem), .memWrite_mem(memWrite_mem), .regWrt_mem(regWrt_mem),
    .jumpMem_mem(jumpMem_mem), .valid_mem(valid_mem),
    .writeBackControl_mem(writeBackControl_mem),
`ifdef EX_PERF_CNT_EN
    .branch_taken_cnt(branch_taken_cnt), .squash_cnt(squash_cnt),
`endif
    .flag_z(flag_z), .flag_n(flag_n)
  );

  typedef struct {
    logic [2:0]  op;
    logic        src, mr, mw, rw, bz, bn, j, jm;
    logic [1:0]  wb;
    logic [31:0] xrs, xrt, y;
    logic        redir, chk;
    logic [31:0] alu;
    logic        valid, emr, emw, erw, ejm;
    logic [1:0]  ewb;
    logic        fz, fn;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vec [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pcy);
    aluOp_ex = v.op; aluSrc_ex = v.src; memRead_ex = v.mr; memWrite_ex = v.mw;
    regWrt_ex = v.rw; branchZero_ex = v.bz; branchNeg_ex = v.bn; jump_ex = v.j;
    jumpMem_ex = v.jm; writeBackControl_ex = v.wb; pc_plus_y_ex = pcy;
    xrs_ex = v.xrs; xrt_ex = v.xrt; y_ex = v.y;
  endtask

  // Simple single-field instruction used by the hand-written sequences.
  function automatic vec_t ins(input logic [2:0] op, input logic j, input logic rw,
                               input logic mw, input logic [31:0] xrs);
    vec_t v;
    v = '{op, 1'b0, 1'b0, mw, rw, 1'b0, 1'b0, j, 1'b0, 2'd0, xrs, 32'd0, 32'd0,
          1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    return v;
  endfunction

  initial begin
    //          op     src mr mw rw bz bn j  jm wb     xrs            xrt     y
    //          redir chk alu           valid emr emw erw ejm ewb  fz fn
    vec[0]  = '{3'b001,1,0,0,1,0,0,0,0,2'd1, 32'd5,        32'd0,  32'd5,
                1'b0,1'b1,32'd0,        1,0,0,1,0,2'd1,1,0};
    vec[1]  = '{3'b000,0,0,0,1,0,0,0,0,2'd0, 32'hFFFFFFFF, 32'd1,  32'd0,
                1'b0,1'b1,32'd0,        1,0,0,1,0,2'd0,1,0};
    vec[2]  = '{3'b010,0,0,0,1,0,0,0,0,2'd0, 32'd3,        32'd0,  32'd0,
                1'b0,1'b1,32'hFFFFFFFD, 1,0,0,1,0,2'd0,0,1};
    vec[3]  = '{3'b011,0,0,0,0,0,1,0,0,2'd0, 32'h40,       32'd0,  32'd0,
                1'b1,1'b1,32'h40,       1,0,0,0,0,2'd0,0,1};
    vec[4]  = '{3'b111,0,0,1,1,0,0,0,0,2'd0, 32'd7,        32'd0,  32'd0,
                1'b0,1'b0,32'd0,        0,0,0,0,0,2'd0,0,1};
    vec[5]  = '{3'b011,0,0,0,0,0,0,1,0,2'd0, 32'h99,       32'd0,  32'd0,
                1'b0,1'b0,32'd0,        0,0,0,0,0,2'd0,0,1};
    vec[6]  = '{3'b100,1,0,1,0,0,0,0,0,2'd0, 32'd0,        32'd0,  32'h10,
                1'b0,1'b1,32'h10,       1,0,1,0,0,2'd0,0,1};
    vec[7]  = '{3'b000,0,0,0,0,1,0,0,0,2'd0, 32'd1,        32'd2,  32'd0,
                1'b0,1'b1,32'd3,        1,0,0,0,0,2'd0,0,1};
    vec[8]  = '{3'b101,0,0,0,1,0,0,0,0,2'd3, 32'hF0,       32'h3C, 32'd0,
                1'b0,1'b1,32'h30,       1,0,0,1,0,2'd3,0,0};
    vec[9]  = '{3'b110,0,0,0,0,0,0,1,0,2'd0, 32'h20,       32'h0F, 32'd0,
                1'b1,1'b1,32'h2F,       1,0,0,0,0,2'd0,0,0};
    vec[10] = '{3'b010,0,0,0,1,0,0,1,0,2'd0, 32'h99,       32'd0,  32'd0,
                1'b0,1'b0,32'd0,        0,0,0,0,0,2'd0,0,0};
    vec[11] = '{3'b011,0,0,0,0,0,0,1,0,2'd0, 32'h99,       32'd0,  32'd0,
                1'b0,1'b0,32'd0,        0,0,0,0,0,2'd0,0,0};
    vec[12] = '{3'b111,0,0,0,1,0,0,0,0,2'd0, 32'd0,        32'd0,  32'd0,
                1'b0,1'b1,32'd0,        1,0,0,1,0,2'd0,1,0};
    vec[13] = '{3'b011,0,1,0,1,0,0,0,1,2'd2, 32'h80000000, 32'd0,  32'd0,
                1'b0,1'b1,32'h80000000, 1,1,0,1,1,2'd2,1,0};

    reset = 1'b1; stall = 1'b0;
    drive(ins(3'b111, 1'b0, 1'b0, 1'b0, 32'd0), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_valid", {31'd0, valid_mem}, 32'd0);
    chk("reset_alu", alu_result_mem, 32'd0);
    chk("reset_flags", {30'd0, flag_z, flag_n}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vec[i], 32'h1000 + i);
      #1;
      chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vec[i].redir});
      if (vec[i].redir) chk($sformatf("v%0d_target", i), redirect_target, vec[i].xrs);
      @(posedge clock); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, valid_mem}, {31'd0, vec[i].valid});
      chk($sformatf("v%0d_ctl", i), {28'd0, memRead_mem, memWrite_mem, regWrt_mem, jumpMem_mem},
          {28'd0, vec[i].emr, vec[i].emw, vec[i].erw, vec[i].ejm});
      chk($sformatf("v%0d_flags", i), {30'd0, flag_z, flag_n}, {30'd0, vec[i].fz, vec[i].fn});
      if (vec[i].chk) begin
        chk($sformatf("v%0d_alu", i), alu_result_mem, vec[i].alu);
        chk($sformatf("v%0d_xrt", i), xrt_mem, vec[i].xrt);
        chk($sformatf("v%0d_pcy", i), pc_plus_y_mem, 32'h1000 + i);
        chk($sformatf("v%0d_wb", i), {30'd0, writeBackControl_mem}, {30'd0, vec[i].ewb});
      end
      @(negedge clock);
    end

    // Stall held three cycles with one squash slot left (flags z=1 n=0 from vec 12).
    drive(ins(3'b011, 1'b1, 1'b0, 1'b0, 32'h50), 32'd0);
    #1 chk("st_redirect", {31'd0, redirect}, 32'd1);
    @(negedge clock);
    drive(ins(3'b011, 1'b0, 1'b0, 1'b0, 32'h11), 32'd0);
    @(negedge clock);
    stall = 1'b1;
    drive(ins(3'b111, 1'b1, 1'b1, 1'b1, 32'h22), 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_hold_redirect", {31'd0, redirect}, 32'd0);
      @(posedge clock); #1;
      chk("st_hold_alu", alu_result_mem, 32'h11);
      chk("st_hold_ctl", {29'd0, valid_mem, memWrite_mem, regWrt_mem}, 32'd0);
      chk("st_hold_flags", {30'd0, flag_z, flag_n}, 32'b10);
      @(negedge clock);
    end
    stall = 1'b0;
    drive(ins(3'b011, 1'b1, 1'b0, 1'b1, 32'h33), 32'd0);
    #1 chk("st_rel_redirect", {31'd0, redirect}, 32'd0);
    @(posedge clock); #1;
    chk("st_rel_valid", {30'd0, valid_mem, memWrite_mem}, 32'd0);
    @(negedge clock);
    drive(ins(3'b011, 1'b0, 1'b0, 1'b0, 32'h44), 32'd0);
    @(posedge clock); #1;
    chk("st_after_valid", {31'd0, valid_mem}, 32'd1);
    chk("st_after_alu", alu_result_mem, 32'h44);
    @(negedge clock);

    // Async reset mid-squash with flag_z=1.
    drive(ins(3'b011, 1'b1, 1'b0, 1'b0, 32'h60), 32'd0);
    @(posedge clock); #1;
    chk("rs_pre_valid", {31'd0, valid_mem}, 32'd1);
    chk("rs_pre_fz", {31'd0, flag_z}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rs_async_alu", alu_result_mem, 32'd0);
    chk("rs_async_ctl", {29'd0, valid_mem, flag_z, flag_n}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(ins(3'b100, 1'b0, 1'b1, 1'b0, 32'd0), 32'd0);
    aluSrc_ex = 1'b1; y_ex = 32'd5;
    @(posedge clock); #1;
    chk("rs_post_valid", {31'd0, valid_mem}, 32'd1);
    chk("rs_post_alu", alu_result_mem, 32'd5);
    chk("rs_post_rw", {31'd0, regWrt_mem}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
